// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the CPU / UART-DMA memory arbiter.
// Holds the transaction FSM encoding and the peripheral address decode bit.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } bus_state_e;

  localparam int DATA_W          = 32;
  localparam int PERIPH_ADDR_BIT = 30;

  function automatic logic is_periph(input logic [DATA_W-1:0] addr);
    return addr[PERIPH_ADDR_BIT];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection between master 0 and master 1.
// Round-robin on ties, unless the current owner holds a lock with burst budget left.
module rr_pick #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic             owner_i,
  input  logic             lock_valid_i,
  input  logic [CNT_W-1:0] burst_cnt_i,
  output logic             winner_o
);

  logic lock_keeps;

  assign lock_keeps = lock_valid_i && (burst_cnt_i < CNT_W'(MAX_BURST));

  always_comb begin
    winner_o = owner_i;
    if (req0_i && !req1_i) begin
      winner_o = 1'b0;
    end else if (req1_i && !req0_i) begin
      winner_o = 1'b1;
    end else if (req0_i && req1_i) begin
      // Lock only matters when both compete; an exhausted burst hands over.
      winner_o = lock_keeps ? owner_i : ~owner_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto a data memory and a peripheral bus.
// One transaction per IDLE -> ACCESS -> RESP pass; addr[30] picks the target bus.
//
//   state  | meaning
//   IDLE   | pick a winner among requesters, capture its transaction
//   ACCESS | single-cycle strobe on mem or per bus, sample read data
//   RESP   | done pulse + rdata to owner, sample owner's lock request
module mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              per_rd,
  output logic              per_wr,
  output logic [DATA_W-1:0] per_addr,
  output logic [DATA_W-1:0] per_wdata,
  input  logic [DATA_W-1:0] per_rdata,

  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  bus_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              lock_valid_q, lock_valid_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              winner;
  logic              in_access;
  logic              periph;
  logic [DATA_W-1:0] rsample;

  rr_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_rr_pick (
    .req0_i       (m0_req),
    .req1_i       (m1_req),
    .owner_i      (owner_q),
    .lock_valid_i (lock_valid_q),
    .burst_cnt_i  (burst_cnt_q),
    .winner_o     (winner)
  );

  assign in_access = (state_q == ACCESS);
  assign periph    = is_periph(addr_q);
  assign rsample   = wr_q ? '0 : (periph ? per_rdata : mem_rdata);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_valid_d = lock_valid_q;
    burst_cnt_d  = burst_cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          owner_d = winner;
          wr_d    = winner ? m1_wr    : m0_wr;
          addr_d  = winner ? m1_addr  : m0_addr;
          wdata_d = winner ? m1_wdata : m0_wdata;
          // A locked re-win extends the burst; anything else starts a new one.
          if ((winner == owner_q) && lock_valid_q) begin
            if (burst_cnt_q != CNT_W'(MAX_BURST)) begin
              burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
          end else begin
            burst_cnt_d = CNT_W'(1);
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (owner_q) begin
          m1_rdata_d = rsample;
        end else begin
          m0_rdata_d = rsample;
        end
      end
      RESP: begin
        state_d      = IDLE;
        lock_valid_d = owner_q ? m1_lock : m0_lock;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b1;
      lock_valid_q <= 1'b0;
      burst_cnt_q  <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_valid_q <= lock_valid_d;
      burst_cnt_q  <= burst_cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Outputs decode straight from state_q so reset kills strobes immediately.
  assign mem_rd    = in_access && !periph && !wr_q;
  assign mem_wr    = in_access && !periph &&  wr_q;
  assign per_rd    = in_access &&  periph && !wr_q;
  assign per_wr    = in_access &&  periph &&  wr_q;
  assign mem_addr  = in_access ? addr_q  : '0;
  assign per_addr  = in_access ? addr_q  : '0;
  assign mem_wdata = in_access ? wdata_q : '0;
  assign per_wdata = in_access ? wdata_q : '0;

  assign m0_done  = (state_q == RESP) && !owner_q;
  assign m1_done  = (state_q == RESP) &&  owner_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: single-transaction vector table,
// plus arbitration, lock-burst and reset-abort sequences with a done scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr, per_rd, per_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, per_addr, per_wdata, per_rdata;
  logic        busy, owner;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .per_rd(per_rd), .per_wr(per_wr), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_rdata(per_rdata),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [31:0] prd;
    logic [3:0]  strb;   // {mem_rd, mem_wr, per_rd, per_wr}
    logic [31:0] rdata;
    bit          poke;
  } vec_t;

  typedef struct {
    bit          m;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] last_rd [2];
  int          total = 0;
  int          bad = 0;
  int          done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any done pulse seen there.
  task automatic tick();
    exp_t e;
    bit   who;
    @(negedge clk);
    if (m0_done === 1'b1 || m1_done === 1'b1) begin
      if (m0_done && m1_done) begin
        total++; bad++;
        $display("FAIL dual_done actual=both required=one");
      end else begin
        who = m1_done;
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done actual=m%0d required=none", who);
        end else begin
          e = sbq.pop_front();
          check("sb_master", 32'(who), 32'(e.m));
          check("sb_rdata", who ? m1_rdata : m0_rdata, e.rdata);
          done_seen++;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.m) begin
      m1_req = 1'b1; m1_wr = v.wr; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_wr = v.wr; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    mem_rdata = v.mrd;
    per_rdata = v.prd;
    tick();
    check("acc_busy", 32'(busy), 1);
    check("acc_strb", 32'({mem_rd, mem_wr, per_rd, per_wr}), 32'(v.strb));
    check("acc_no_done", 32'({m0_done, m1_done}), 0);
    check("acc_addr", (v.strb[3:2] != 2'b00) ? mem_addr : per_addr, v.addr);
    if (v.wr) check("acc_wdata", (v.strb[3:2] != 2'b00) ? mem_wdata : per_wdata, v.wdata);
    if (v.poke) begin
      m0_addr = 32'h0000_0FF0;
      #1;
      check("hold_addr", mem_addr, v.addr);
    end
    sbq.push_back('{m: v.m, rdata: v.rdata});
    tick();
    check("resp_done", 32'(v.m ? m1_done : m0_done), 1);
    check("resp_strb", 32'({mem_rd, mem_wr, per_rd, per_wr}), 0);
    check("other_rdata", v.m ? m0_rdata : m1_rdata, last_rd[~v.m]);
    last_rd[v.m] = v.rdata;
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_bus", mem_addr | per_addr | mem_wdata | per_wdata, 0);
    check("idle_owner", 32'(owner), 32'(v.m));
    check("hold_rdata", v.m ? m1_rdata : m0_rdata, v.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{0, 0, 32'h0000_0010, 32'h0,          32'h1234_5678, 32'hFFFF_0000, 4'b1000, 32'h1234_5678, 1};
    vecs[1] = '{1, 1, 32'h4000_0008, 32'h0000_00A5,  32'h1111_1111, 32'h2222_2222, 4'b0001, 32'h0,         0};
    vecs[2] = '{0, 1, 32'h0000_0100, 32'hCAFE_F00D,  32'h3333_3333, 32'h4444_4444, 4'b0100, 32'h0,         0};
    vecs[3] = '{1, 0, 32'h4000_0020, 32'h0,          32'h5555_0000, 32'h0BAD_BEEF, 4'b0010, 32'h0BAD_BEEF, 0};
    vecs[4] = '{0, 0, 32'h4000_0004, 32'h0,          32'h6666_6666, 32'h55AA_55AA, 4'b0010, 32'h55AA_55AA, 0};
    vecs[5] = '{1, 0, 32'hBFFF_FFFC, 32'h0,          32'h8765_4321, 32'h7777_7777, 4'b1000, 32'h8765_4321, 0};

    reset = 1'b1;
    {m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock} = '0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata} = '0;
    mem_rdata = 32'hDEAD_0001;
    per_rdata = 32'hDEAD_0002;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 1);
    check("rst_strb", 32'({mem_rd, mem_wr, per_rd, per_wr, m0_done, m1_done}), 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    check("rst_bus", mem_addr | per_addr | mem_wdata | per_wdata, 0);
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both masters requesting without lock: strict alternation starting with m0.
    do_reset();
    m0_addr = 32'h0000_0020; m1_addr = 32'h4000_0040;
    mem_rdata = 32'h1111_1111; per_rdata = 32'h2222_2222;
    for (int i = 0; i < 4; i++) sbq.push_back('{m: i[0], rdata: i[0] ? 32'h2222_2222 : 32'h1111_1111});
    done_seen = 0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 40 && done_seen < 4; c++) tick();
    m0_req = 1'b0; m1_req = 1'b0;
    check("alt_count", 32'(done_seen), 4);
    repeat (2) tick();

    // m1 locked: m0 first (reset tie), then 8 m1 grants, then m0 regains.
    do_reset();
    sbq.push_back('{m: 0, rdata: 32'h1111_1111});
    for (int i = 0; i < 8; i++) sbq.push_back('{m: 1, rdata: 32'h2222_2222});
    sbq.push_back('{m: 0, rdata: 32'h1111_1111});
    done_seen = 0;
    m1_lock = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 80 && done_seen < 10; c++) tick();
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    check("lock_count", 32'(done_seen), 10);
    check("lock_sb_empty", 32'(sbq.size()), 0);
    repeat (2) tick();

    // Reset mid-ACCESS: strobe drops at once, no done, clean restart.
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h0000_0030;
    mem_rdata = 32'h3333_3333;
    tick();
    check("abort_pre_strb", 32'(mem_rd), 1);
    reset = 1'b1;
    #1;
    check("abort_strb", 32'({mem_rd, mem_wr, per_rd, per_wr}), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_rdata", m0_rdata | m1_rdata, 0);
    m0_req = 1'b0;
    done_seen = 0;
    tick();
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) tick();
    check("abort_no_done", 32'(done_seen), 0);
    run_vec('{1, 1, 32'h4000_0010, 32'h0000_0077, 32'h0, 32'h9999_9999, 4'b0001, 32'h0, 0});

    check("final_sb_empty", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
